fifo_buffer: RTL and testbench
==============================

Name: fifo_buffer

Overview:
- Synchronous byte FIFO between the MAC receive stream and the MAC transmit controller in the Ethernet bridge.
- Stores received frame bytes together with an end-of-frame marker.
- Reports empty and full status.
- Asserts tx_valid_flag while at least one complete frame is stored, so the transmit side only starts once a whole frame is available.

Parameters:
- DATA_W, 8, width of a data byte/word.
- ADDR_W, 11, address width; DEPTH = 2**ADDR_W entries (2048, which holds a maximum-size 1518-byte frame).

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- write  input  1  write enable; stores data_in and rx_mac_last when not full.
- data_in  input  DATA_W  byte from the MAC receive path.
- rx_mac_last  input  1  marks data_in as the last byte of a frame; sampled only together with an accepted write.
- read  input  1  read enable; pops one entry when not empty.
- data_out  output  DATA_W  registered read data.
- empty  output  1  no entries stored.
- full  output  1  DEPTH entries stored.
- tx_valid_flag  output  1  at least one complete frame stored.

Behaviour:
- Storage: DEPTH x (DATA_W+1) memory. The extra bit is the last-byte marker.
- State: write pointer wr_ptr, read pointer rd_ptr, entry count cnt (ADDR_W+1 bits), frame count fcnt (ADDR_W+1 bits).
- Reset (rst=1 at a clock edge):
  - wr_ptr, rd_ptr, cnt, fcnt and data_out all go to 0.
  - Resulting outputs: empty=1, full=0, tx_valid_flag=0.
  - Memory contents are not cleared.
  - Reset overrides a simultaneous read or write.
- Accepted write (wr_ok = write & ~full):
  - mem[wr_ptr] <= {rx_mac_last, data_in}.
  - wr_ptr increments and wraps from DEPTH-1 to 0.
- Accepted read (rd_ok = read & ~empty):
  - data_out <= mem[rd_ptr] data bits.
  - rd_ptr increments and wraps.
  - Latency: the popped byte is visible on data_out the cycle after the read edge.
- data_out holds its value whenever no read is accepted.
- Write when full: ignored; no pointer, count or memory change.
- Read when empty: ignored; data_out holds.
- Simultaneous wr_ok and rd_ok: both are performed and cnt is unchanged.
  - If empty, read is not accepted, so write-through is not possible.
  - If full, write is not accepted.
- cnt: +1 on wr_ok only, -1 on rd_ok only.
- Status outputs, combinational from registers:
  - empty = (cnt==0).
  - full = (cnt==DEPTH).
- fcnt:
  - +1 when wr_ok & rx_mac_last.
  - -1 when rd_ok and the popped entry's marker bit = 1.
  - Both in the same cycle: unchanged.
- tx_valid_flag = (fcnt != 0), combinational from fcnt.
  - It rises the cycle after the last byte of a frame is written.
  - It falls the cycle after the last stored frame's final byte is read.
- Bytes written without rx_mac_last stay in the FIFO as a partial frame. They are readable if read is asserted, but they do not raise tx_valid_flag.
- fcnt can never exceed cnt, so no saturation is required.

Optional Feature:
- Macro: FIFO_BUFFER_LEVEL_EN.
- When defined:
  - Adds output port level (ADDR_W+1 bits), equal to cnt.
  - Adds output port frame_count (ADDR_W+1 bits), equal to fcnt.
  - Both reset to 0 and update on the same edges as the internal registers.
- When undefined: these ports do not exist. All other behaviour is identical.

Test Plan:
- Reset check: assert rst 2 cycles -> empty=1, full=0, tx_valid_flag=0, data_out=0; read pulse while empty -> data_out stays 0.
- Single frame: write 0x11,0x22,0x33 with rx_mac_last on 0x33 -> tx_valid_flag=0 until the cycle after the 0x33 write, then 1.
  - Then 3 reads -> data_out shows 0x11,0x22,0x33, each one cycle after its read.
  - tx_valid_flag=0 and empty=1 after the third read.
- Two frames back to back: frame A (2 bytes), frame B (3 bytes), both terminated -> fcnt reaches 2.
  - After reading frame A, tx_valid_flag stays 1.
  - After reading frame B, it drops.
- Full/overflow: write DEPTH bytes with no last marker -> full=1 and tx_valid_flag=0.
  - Extra write of 0xAA is dropped.
  - Reading DEPTH bytes returns the original sequence; empty=1 at the end.
- Simultaneous read/write: with 5 entries stored, assert read and write together for 10 cycles -> cnt stays 5, data order is preserved, and pointers wrap correctly when started near DEPTH-1.
- Mid-operation reset: rst during a partially read frame -> next cycle empty=1 and tx_valid_flag=0; a subsequent new frame reads back correctly.

Source files
------------

// File: rtl/fifo_buffer.sv
// fifo_buffer: synchronous byte FIFO between the MAC receive stream and the
// MAC transmit controller. Each entry carries a data byte plus an
// end-of-frame marker. tx_valid_flag is high while at least one complete
// frame is stored.
//
// Optional build macro FIFO_BUFFER_LEVEL_EN adds the observation ports
// level (entry count) and frame_count (complete frames stored).
module fifo_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rx_mac_last,
    input  logic              read,
    output logic [DATA_W-1:0] data_out,
    output logic              empty,
    output logic              full,
    output logic              tx_valid_flag
`ifdef FIFO_BUFFER_LEVEL_EN
    ,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W:0]   frame_count
`endif
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};

    // Bit DATA_W of each entry is the end-of-frame marker.
    logic [DATA_W:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic [ADDR_W:0]   fcnt;

    logic wr_ok;
    logic rd_ok;
    logic wr_last;
    logic rd_last;

    assign empty         = (cnt == '0);
    assign full          = (cnt == CNT_FULL);
    assign tx_valid_flag = (fcnt != '0);

    assign wr_ok   = write & ~full;
    assign rd_ok   = read & ~empty;
    // A frame completes on write of a marked byte and retires when that
    // marked byte is popped.
    assign wr_last = wr_ok & rx_mac_last;
    assign rd_last = rd_ok & mem[rd_ptr][DATA_W];

`ifdef FIFO_BUFFER_LEVEL_EN
    assign level       = cnt;
    assign frame_count = fcnt;
`endif

    // Storage write; contents survive reset, but reset blocks a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr] <= {rx_mac_last, data_in};
        end
    end

    // Pointers, entry count and complete-frame count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            fcnt   <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            case ({wr_last, rd_last})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    // Registered read data; holds whenever no read is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
        end else if (rd_ok) begin
            data_out <= mem[rd_ptr][DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_fifo_buffer.sv
// tb_fifo_buffer: directed scenarios plus a randomized phase, checked every
// cycle against a queue-based model of the FIFO, with literal expectations
// at key points of the directed scenarios.
module tb_fifo_buffer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 11;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              write;
    logic [DATA_W-1:0] data_in;
    logic              rx_mac_last;
    logic              read;
    logic [DATA_W-1:0] data_out;
    logic              empty;
    logic              full;
    logic              tx_valid_flag;
`ifdef FIFO_BUFFER_LEVEL_EN
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   frame_count;
`endif

    fifo_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .write         (write),
        .data_in       (data_in),
        .rx_mac_last   (rx_mac_last),
        .read          (read),
        .data_out      (data_out),
        .empty         (empty),
        .full          (full),
        .tx_valid_flag (tx_valid_flag)
`ifdef FIFO_BUFFER_LEVEL_EN
        ,
        .level         (level),
        .frame_count   (frame_count)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Reference model: a queue of {last, byte} entries.
    logic [DATA_W:0]   q[$];
    int                m_fcnt = 0;
    logic [DATA_W-1:0] m_dout = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit wr_ok;
        bit rd_ok;
        logic [DATA_W:0] e;
        if (rst) begin
            q.delete();
            m_fcnt = 0;
            m_dout = '0;
        end else begin
            wr_ok = write && (q.size() < DEPTH);
            rd_ok = read && (q.size() > 0);
            if (rd_ok) begin
                e = q.pop_front();
                m_dout = e[DATA_W-1:0];
                if (e[DATA_W]) m_fcnt--;
            end
            if (wr_ok) begin
                q.push_back({rx_mac_last, data_in});
                if (rx_mac_last) m_fcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("empty", empty, q.size() == 0);
            chk("full", full, q.size() == DEPTH);
            chk("tx_valid_flag", tx_valid_flag, m_fcnt != 0);
            chk("data_out", data_out, m_dout);
`ifdef FIFO_BUFFER_LEVEL_EN
            chk("level", level, q.size());
            chk("frame_count", frame_count, m_fcnt);
`endif
        end
    end

    // Apply one cycle of inputs (called at a negedge), return at the next negedge.
    task automatic cyc(input logic r, input logic w, input logic rd,
                       input logic [DATA_W-1:0] d, input logic l);
        rst = r; write = w; read = rd; data_in = d; rx_mac_last = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; write = 1'b0; read = 1'b0; data_in = '0; rx_mac_last = 1'b0;
        @(negedge clk);
        cyc(1, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);
        chk_en = 1'b1;

        // Reset state
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_txv", tx_valid_flag, 0);
        chk("rst_dout", data_out, 0);
        cyc(0, 0, 1, 8'h00, 0);
        chk("rd_empty_dout", data_out, 0);
        chk("rd_empty_empty", empty, 1);

        // Single frame
        cyc(0, 1, 0, 8'h11, 0);
        chk("sf_txv_a", tx_valid_flag, 0);
        cyc(0, 1, 0, 8'h22, 0);
        chk("sf_txv_b", tx_valid_flag, 0);
        cyc(0, 1, 0, 8'h33, 1);
        chk("sf_txv_c", tx_valid_flag, 1);
        cyc(0, 0, 1, 8'h00, 0);
        chk("sf_d0", data_out, 8'h11);
        cyc(0, 0, 1, 8'h00, 0);
        chk("sf_d1", data_out, 8'h22);
        chk("sf_txv_d", tx_valid_flag, 1);
        cyc(0, 0, 1, 8'h00, 0);
        chk("sf_d2", data_out, 8'h33);
        chk("sf_txv_e", tx_valid_flag, 0);
        chk("sf_empty", empty, 1);

        // Two frames back to back
        cyc(0, 1, 0, 8'h41, 0);
        cyc(0, 1, 0, 8'h42, 1);
        cyc(0, 1, 0, 8'h51, 0);
        cyc(0, 1, 0, 8'h52, 0);
        cyc(0, 1, 0, 8'h53, 1);
        chk("tf_model_fcnt", m_fcnt, 2);
        chk("tf_model_cnt", q.size(), 5);
        cyc(0, 0, 1, 8'h00, 0);
        cyc(0, 0, 1, 8'h00, 0);
        chk("tf_a_last", data_out, 8'h42);
        chk("tf_txv_after_a", tx_valid_flag, 1);
        cyc(0, 0, 1, 8'h00, 0);
        cyc(0, 0, 1, 8'h00, 0);
        cyc(0, 0, 1, 8'h00, 0);
        chk("tf_b_last", data_out, 8'h53);
        chk("tf_txv_after_b", tx_valid_flag, 0);

        // Fill to full with no frame marker, then overflow
        for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, 8'(i * 7 + 3), 0);
        chk("full_full", full, 1);
        chk("full_txv", tx_valid_flag, 0);
        cyc(0, 1, 0, 8'hAA, 0);
        chk("ovf_full", full, 1);
        chk("ovf_model", q.size(), DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            cyc(0, 0, 1, 8'h00, 0);
            if (data_out !== 8'(i * 7 + 3)) chk("drain_seq", data_out, 8'(i * 7 + 3));
            else total++;
        end
        chk("drain_empty", empty, 1);

        // Advance pointers near the top of memory via streaming read+write
        cyc(0, 1, 0, 8'h01, 0);
        for (int i = 0; i < 2030; i++) cyc(0, 1, 1, 8'(i), 0);
        cyc(0, 0, 1, 8'h00, 0);
        chk("adv_empty", empty, 1);

        // Five stored, then ten simultaneous read/write cycles across the wrap
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, 8'hC0 + 8'(k), 0);
        for (int j = 0; j < 10; j++) begin
            cyc(0, 1, 1, 8'hC5 + 8'(j), 0);
            chk("sim_dout", data_out, 8'hC0 + 8'(j));
            chk("sim_cnt", q.size(), 5);
        end
        for (int j = 0; j < 5; j++) begin
            cyc(0, 0, 1, 8'h00, 0);
            chk("sim_tail", data_out, 8'hCA + 8'(j));
        end
        chk("sim_empty", empty, 1);

        // Reset in the middle of a partially read frame
        cyc(0, 1, 0, 8'h61, 0);
        cyc(0, 1, 0, 8'h62, 0);
        cyc(0, 1, 0, 8'h63, 1);
        cyc(0, 0, 1, 8'h00, 0);
        chk("mr_d0", data_out, 8'h61);
        cyc(1, 1, 1, 8'h99, 1);
        chk("mr_empty", empty, 1);
        chk("mr_txv", tx_valid_flag, 0);
        chk("mr_dout", data_out, 0);
        cyc(0, 1, 0, 8'h71, 0);
        cyc(0, 1, 0, 8'h72, 1);
        chk("mr_txv_new", tx_valid_flag, 1);
        cyc(0, 0, 1, 8'h00, 0);
        chk("mr_n0", data_out, 8'h71);
        cyc(0, 0, 1, 8'h00, 0);
        chk("mr_n1", data_out, 8'h72);
        chk("mr_txv_end", tx_valid_flag, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                ($urandom_range(0, 99) < 55),
                ($urandom_range(0, 99) < 50),
                8'($urandom),
                ($urandom_range(0, 9) == 0));
        end
        cyc(0, 0, 0, 8'h00, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
